// File: rtl/soric_slave_arbiter.sv
// soric_slave_arbiter: round-robin sharing of one OBI-style slave port among MASTERS requesters,
// with an in-order ID FIFO that steers each slave response back to the master that issued it.
module soric_slave_arbiter #(
   parameter int MASTERS     = 4,
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 32,
   parameter int OUTSTANDING = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [MASTERS-1:0]              m_req_i,
   input  logic [MASTERS*ADDR_WIDTH-1:0]   m_addr_i,
   input  logic [MASTERS-1:0]              m_we_i,
   input  logic [MASTERS*DATA_WIDTH/8-1:0] m_be_i,
   input  logic [MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
   output logic [MASTERS-1:0]              m_gnt_o,
   output logic [MASTERS-1:0]              m_rvalid_o,
   output logic [DATA_WIDTH-1:0]           m_rdata_o,
   output logic                            s_req_o,
   output logic [ADDR_WIDTH-1:0]           s_addr_o,
   output logic                            s_we_o,
   output logic [DATA_WIDTH/8-1:0]         s_be_o,
   output logic [DATA_WIDTH-1:0]           s_wdata_o,
   input  logic                            s_gnt_i,
   input  logic                            s_rvalid_i,
   input  logic [DATA_WIDTH-1:0]           s_rdata_i,
   output logic                            busy_o,
   output logic                            err_o
);
   localparam int IDW = $clog2(MASTERS);
   localparam int BW  = DATA_WIDTH / 8;
   localparam int PW  = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
   localparam int CW  = $clog2(OUTSTANDING + 1);

   logic [IDW-1:0] rr_ptr, lock_id, rr_sel, sel;
   logic           lock, found, full, empty, hs, pop;
   logic [IDW:0]   idx;
   logic [IDW-1:0] fifo_q [OUTSTANDING];
   logic [PW-1:0]  head, tail;
   logic [CW-1:0]  count;

   // Scan starting at rr_ptr; the first requester found wins.
   always_comb begin
      rr_sel = rr_ptr;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < MASTERS; i++) begin
         idx = {1'b0, rr_ptr} + (IDW+1)'(i);
         idx = idx >= (IDW+1)'(MASTERS) ? idx - (IDW+1)'(MASTERS) : idx;
         if (!found && m_req_i[idx[IDW-1:0]]) begin
            rr_sel = idx[IDW-1:0];
            found  = 1'b1;
         end
      end
   end

   assign sel        = lock ? lock_id : rr_sel;
   assign full       = count == CW'(OUTSTANDING);
   assign empty      = count == '0;
   assign s_req_o    = m_req_i[sel] & ~full;
   assign hs         = s_req_o & s_gnt_i;
   assign pop        = s_rvalid_i & ~empty;
   assign s_addr_o   = m_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
   assign s_we_o     = m_we_i[sel];
   assign s_be_o     = m_be_i[sel*BW +: BW];
   assign s_wdata_o  = m_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
   assign m_gnt_o    = hs ? MASTERS'(1) << sel : '0;
   assign m_rvalid_o = pop ? MASTERS'(1) << fifo_q[head] : '0;
   assign m_rdata_o  = s_rdata_i;
   assign busy_o     = ~empty;

   // A stalled request is locked so the slave sees stable fields until granted.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_ptr  <= '0;
         lock    <= 1'b0;
         lock_id <= '0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         err_o   <= 1'b0;
      end else begin
         lock    <= s_req_o & ~s_gnt_i;
         lock_id <= sel;
         count   <= count + CW'(hs) - CW'(pop);
         err_o   <= err_o | (s_rvalid_i & empty);
         if (hs) begin
            fifo_q[tail] <= sel;
            tail         <= tail == PW'(OUTSTANDING - 1) ? '0 : tail + 1'b1;
            rr_ptr       <= sel == IDW'(MASTERS - 1) ? '0 : sel + 1'b1;
         end
         if (pop)
            head <= head == PW'(OUTSTANDING - 1) ? '0 : head + 1'b1;
      end
   end
endmodule

// File: tb/tb_soric_slave_arbiter.sv
// tb_soric_slave_arbiter: directed and random traffic against a queue-based reference model;
// a monitor process checks every response against the scoreboard.
module tb_soric_slave_arbiter;
   localparam int M  = 4;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int OS = 2;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic [M-1:0]    m_req = '0, m_we = '0;
   logic [M*AW-1:0] m_addr = '0;
   logic [M*BW-1:0] m_be = '0;
   logic [M*DW-1:0] m_wdata = '0;
   logic [M-1:0]    m_gnt_o, m_rvalid_o;
   logic [DW-1:0]   m_rdata_o, s_wdata_o;
   logic            s_req_o, s_we_o, busy_o, err_o;
   logic [AW-1:0]   s_addr_o;
   logic [BW-1:0]   s_be_o;
   logic            s_gnt = 1'b0, s_rvalid = 1'b0;
   logic [DW-1:0]   s_rdata = '0;

   always #5 clk = ~clk;

   soric_slave_arbiter #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING(OS)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we),
      .m_be_i(m_be), .m_wdata_i(m_wdata), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
      .m_rdata_o(m_rdata_o), .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
      .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
      .s_rdata_i(s_rdata), .busy_o(busy_o), .err_o(err_o)
   );

   int n_checks = 0, n_err = 0;
   int exp_id[$];
   logic [DW-1:0] exp_data[$];
   logic [DW-1:0] slave_q[$];
   bit pend[M];
   logic [AW-1:0] p_addr[M];
   logic          p_we[M];
   logic [BW-1:0] p_be[M];
   logic [DW-1:0] p_wdata[M];
   int rr = 0, lock_id = 0;
   bit lock = 0, exp_err = 0, inject_rv = 0, use_ovr = 0;
   logic [M-1:0] one = 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit pend_any();
      bit a = 0;
      for (int k = 0; k < M; k++) a |= pend[k];
      return a;
   endfunction

   // One bus cycle: drive masters and slave, then check against the arbitration rules.
   task automatic step(input bit gnt, input int rv_pct, input logic [M-1:0] new_req);
      int cnt0, sel;
      bit full, rv, req, hs;
      logic [DW-1:0] d;
      @(negedge clk);
      cnt0 = slave_q.size();
      full = cnt0 == OS;
      rv = 0;
      s_rdata = $urandom;
      if (cnt0 > 0 && $urandom_range(1, 100) <= rv_pct) begin
         rv = 1;
         s_rdata = slave_q.pop_front();
      end else if (inject_rv && cnt0 == 0) rv = 1;
      s_rvalid = rv;
      for (int k = 0; k < M; k++) begin
         if (!pend[k] && new_req[k]) begin
            pend[k] = 1;
            p_addr[k] = (use_ovr && k == 2) ? 12'h3F0 : AW'($urandom);
            p_we[k] = 1'($urandom);
            p_be[k] = BW'($urandom);
            p_wdata[k] = $urandom;
         end
         m_req[k] = pend[k];
         m_we[k] = p_we[k];
         m_addr[k*AW +: AW] = p_addr[k];
         m_be[k*BW +: BW] = p_be[k];
         m_wdata[k*DW +: DW] = p_wdata[k];
      end
      s_gnt = gnt;
      #1;
      sel = lock ? lock_id : -1;
      if (!lock)
         for (int i = 0; i < M; i++)
            if (sel < 0 && pend[(rr + i) % M]) sel = (rr + i) % M;
      req = (sel >= 0) ? (pend[sel] && !full) : 0;
      hs = req && gnt;
      chk("s_req", s_req_o, req);
      chk("m_gnt", m_gnt_o, hs ? one << sel : '0);
      chk("busy", busy_o, cnt0 != 0);
      chk("err", err_o, exp_err);
      if (req) begin
         chk("s_addr", s_addr_o, p_addr[sel]);
         chk("s_we", s_we_o, p_we[sel]);
         chk("s_be", s_be_o, p_be[sel]);
         chk("s_wdata", s_wdata_o, p_wdata[sel]);
      end
      if (rv && cnt0 == 0) exp_err = 1;
      if (hs) begin
         d = $urandom;
         exp_id.push_back(sel);
         exp_data.push_back(d);
         slave_q.push_back(d);
         pend[sel] = 0;
         rr = (sel + 1) % M;
         lock = 0;
      end else if (req) begin
         lock = 1;
         lock_id = sel;
      end else lock = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ni = 1'b0;
      m_req = '0;
      s_gnt = 1'b0;
      s_rvalid = 1'b0;
      for (int k = 0; k < M; k++) pend[k] = 0;
      @(negedge clk);
      rst_ni = 1'b1;
      exp_id.delete();
      exp_data.delete();
      slave_q.delete();
      rr = 0;
      lock = 0;
      exp_err = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (slave_q.size() > 0 || pend_any()); i++) step(1, 100, '0);
      chk("drain_done", slave_q.size() + int'(pend_any()), 0);
   endtask

   // Monitor: every response must match the oldest granted request.
   always @(negedge clk) begin
      #2;
      if (rst_ni && m_rvalid_o != '0) begin
         if (exp_id.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL rvalid_unexpected: got %0h expected none", m_rvalid_o);
         end else begin
            chk("rvalid_id", m_rvalid_o, one << exp_id.pop_front());
            chk("rdata", m_rdata_o, exp_data.pop_front());
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_s_req", s_req_o, 0);
      chk("rst_m_gnt", m_gnt_o, 0);
      chk("rst_m_rvalid", m_rvalid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_err", err_o, 0);
      rst_ni = 1'b1;
      repeat (8) step(1, 100, 4'b1111);
      drain();
      step(1, 100, 4'b0010);
      use_ovr = 1;
      repeat (3) begin
         step(0, 100, 4'b1100);
         chk("stall_addr", s_addr_o, 12'h3F0);
      end
      use_ovr = 0;
      step(1, 100, '0);
      chk("stall_gnt_m2", m_gnt_o, 4'b0100);
      step(1, 100, '0);
      chk("next_gnt_m3", m_gnt_o, 4'b1000);
      drain();
      do_reset();
      repeat (3) step(1, 0, 4'b1111);
      chk("full_stall", s_req_o, 0);
      step(1, 100, '0);
      chk("pop_still_stall", s_req_o, 0);
      step(1, 0, '0);
      chk("req_after_pop", s_req_o, 1);
      drain();
      inject_rv = 1;
      step(0, 0, '0);
      inject_rv = 0;
      repeat (3) step(0, 0, '0);
      chk("err_sticky", err_o, 1);
      repeat (2) step(1, 0, 4'b1111);
      do_reset();
      step(0, 0, '0);
      chk("busy_after_rst", busy_o, 0);
      inject_rv = 1;
      step(0, 0, '0);
      inject_rv = 0;
      step(0, 0, '0);
      chk("late_rvalid_err", err_o, 1);
      do_reset();
      repeat (1500) step(1'($urandom), 60, M'($urandom));
      drain();
      @(negedge clk);
      #3;
      chk("scoreboard_empty", exp_id.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
